// File: rtl/ysyx_22051013_mdu_pkg.sv
// Shared encodings, FSM states and width constants for the RV64M multiply/divide unit.
package ysyx_22051013_mdu_pkg;

    localparam int MDU_XLEN = 64;
    localparam int MDU_WLEN = 32;

    // RISC-V funct3 encodings for the M extension
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX,
        S_DONE
    } mdu_state_t;

    // True when rs1 is treated as signed; rs2 is signed as well except for MULHSU.
    function automatic logic is_signed_op(input logic [2:0] f3);
        return !(f3 inside {MDU_MULHU, MDU_DIVU, MDU_REMU});
    endfunction

endpackage

// File: rtl/ysyx_22051013_div_step.sv
// One restoring-division step: shift in the next dividend bit, subtract if it fits.
// Purely combinational; reused every DIV cycle.
module ysyx_22051013_div_step
    import ysyx_22051013_mdu_pkg::*;
#(
    parameter int W = MDU_XLEN
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] divisor,
    input  logic         dvd_bit,
    output logic [W-1:0] rem_next,
    output logic         q_bit
);

    logic [W:0] trial;

    // rem < divisor always holds, so a non-negative trial fits back in W bits
    always_comb begin
        trial    = {rem, dvd_bit} - {1'b0, divisor};
        q_bit    = ~trial[W];
        rem_next = q_bit ? trial[W-1:0] : {rem[W-2:0], dvd_bit};
    end

endmodule

// File: rtl/ysyx_22051013_mdu.sv
// Multi-cycle RV64M multiply/divide: MUL takes N/MUL_BITS+1 cycles, DIV N+1, special cases 1.
// Result held in DONE until out_ready; no new request is taken while busy.
module ysyx_22051013_mdu
    import ysyx_22051013_mdu_pkg::*;
#(
    parameter int XLEN     = MDU_XLEN,
    parameter int MUL_BITS = 2,
    parameter int TAG_W    = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             word,
    input  logic [XLEN-1:0]  src1,
    input  logic [XLEN-1:0]  src2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  result,
    output logic [TAG_W-1:0] out_tag,
    output logic             busy
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam int PW = 2 * XLEN;

    function automatic logic [XLEN-1:0] sext_w(input logic [31:0] v);
        return XLEN'($signed(v));
    endfunction

    mdu_state_t state_q, state_d;

    logic [2:0]       op_q;
    logic             word_q;
    logic [TAG_W-1:0] tag_q;
    logic             a_neg_q, b_neg_q, special_q;
    logic [XLEN-1:0]  spec_q;
    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    mcand_q, prod_q;
    logic [XLEN-1:0]  mplier_q, rem_q, dvd_q, dsr_q;
    logic [XLEN-1:0]  result_q;

    logic             w_en, rs1_sgn, rs2_sgn, a_neg, b_neg, div_op;
    logic             is_zero, is_ovf, is_rsvd, special, accept;
    logic [XLEN-1:0]  a_ext, b_ext, a_mag, b_mag, min_val, dvd_val, spec_val;
    int               n_len;

    logic [PW-1:0]    mul_add, p_fix;
    logic [XLEN-1:0]  q_fix, r_fix, fix_val;
    logic [XLEN-1:0]  step_rem;
    logic             step_q;

    assign in_ready  = (state_q == S_IDLE) && !rst && !flush;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q != S_IDLE);
    assign result    = result_q;
    assign out_tag   = tag_q;

    // Operand preparation: extension, magnitudes and special-case detection
    always_comb begin
        w_en    = word && (XLEN > MDU_WLEN);
        rs1_sgn = is_signed_op(op);
        rs2_sgn = is_signed_op(op) && (op != MDU_MULHSU);
        a_ext   = src1;
        b_ext   = src2;
        if (w_en) begin
            a_ext = rs1_sgn ? sext_w(src1[31:0]) : XLEN'(src1[31:0]);
            b_ext = rs2_sgn ? sext_w(src2[31:0]) : XLEN'(src2[31:0]);
        end
        a_neg   = rs1_sgn && a_ext[XLEN-1];
        b_neg   = rs2_sgn && b_ext[XLEN-1];
        a_mag   = a_neg ? -a_ext : a_ext;
        b_mag   = b_neg ? -b_ext : b_ext;
        n_len   = w_en ? MDU_WLEN : XLEN;
        div_op  = op[2];
        min_val = w_en ? sext_w(32'h8000_0000) : {1'b1, {(XLEN-1){1'b0}}};
        dvd_val = w_en ? sext_w(src1[31:0]) : src1;
        is_zero = div_op && (b_ext == '0);
        is_ovf  = (op inside {MDU_DIV, MDU_REM}) && (a_ext == min_val) && (b_ext == '1);
        is_rsvd = w_en && (op inside {MDU_MULH, MDU_MULHSU, MDU_MULHU});
        special = is_zero || is_ovf || is_rsvd;
        spec_val = '0;
        if (is_zero)
            spec_val = (op inside {MDU_REM, MDU_REMU}) ? dvd_val : '1;
        else if (is_ovf)
            spec_val = (op == MDU_REM) ? '0 : dvd_val;
    end

    always_comb begin
        mul_add = '0;
        for (int i = 0; i < MUL_BITS; i++)
            if (mplier_q[i]) mul_add = mul_add + (mcand_q << i);
    end

    ysyx_22051013_div_step #(.W(XLEN)) u_div_step (
        .rem      (rem_q),
        .divisor  (dsr_q),
        .dvd_bit  (dvd_q[XLEN-1]),
        .rem_next (step_rem),
        .q_bit    (step_q)
    );

    // Sign fix-up and half/word selection; remainder follows the dividend's sign
    always_comb begin
        p_fix   = (a_neg_q ^ b_neg_q) ? -prod_q : prod_q;
        q_fix   = (a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q;
        r_fix   = a_neg_q ? -rem_q : rem_q;
        fix_val = '0;
        if (special_q)
            fix_val = spec_q;
        else if (op_q[2])
            fix_val = (op_q inside {MDU_REM, MDU_REMU}) ? r_fix : q_fix;
        else if (op_q == MDU_MUL)
            fix_val = p_fix[XLEN-1:0];
        else
            fix_val = p_fix[PW-1:XLEN];
        if (word_q)
            fix_val = sext_w(fix_val[31:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: if (accept) state_d = special ? S_FIX : (div_op ? S_DIV : S_MUL);
            S_MUL,
            S_DIV:  if (cnt_q == CW'(1)) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q      <= '0;
            word_q    <= 1'b0;
            tag_q     <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            special_q <= 1'b0;
            spec_q    <= '0;
            cnt_q     <= '0;
            mcand_q   <= '0;
            prod_q    <= '0;
            mplier_q  <= '0;
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            result_q  <= '0;
        end else if (accept) begin
            op_q      <= op;
            word_q    <= w_en;
            tag_q     <= in_tag;
            a_neg_q   <= a_neg;
            b_neg_q   <= b_neg;
            special_q <= special;
            spec_q    <= spec_val;
            cnt_q     <= div_op ? CW'(n_len) : CW'(n_len / MUL_BITS);
            mcand_q   <= PW'(a_mag);
            prod_q    <= '0;
            mplier_q  <= b_mag;
            rem_q     <= '0;
            // W dividends are left-aligned so the step always consumes the MSB
            dvd_q     <= w_en ? (a_mag << MDU_WLEN) : a_mag;
            dsr_q     <= b_mag;
        end else begin
            unique case (state_q)
                S_MUL: begin
                    prod_q   <= prod_q + mul_add;
                    mcand_q  <= mcand_q << MUL_BITS;
                    mplier_q <= mplier_q >> MUL_BITS;
                    cnt_q    <= cnt_q - CW'(1);
                end
                S_DIV: begin
                    rem_q <= step_rem;
                    dvd_q <= {dvd_q[XLEN-2:0], step_q};
                    cnt_q <= cnt_q - CW'(1);
                end
                S_FIX: result_q <= fix_val;
                default: ;
            endcase
        end
    end

endmodule
